muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU. It accepts one M-extension operation per handshake and runs a radix-2 shift-add multiply or restoring divide over 32 iterations on one shared 33-bit adder/subtractor. It returns one 32-bit result with a single-cycle valid pulse. The pipeline controller stalls the EX stage on `!ready` and on an accepted op until `out_valid`, and issues `kill` on flush.

## Interface
No parameters; width fixed at 32.
- `clk` in 1: sole clock. All state is updated on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request to begin an operation. Sampled only while `ready`=1.
- `op` in 3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in1` in 32: rs1 operand (multiplicand/dividend).
- `in2` in 32: rs2 operand (multiplier/divisor).
- `kill` in 1: abort the current operation.
- `ready` out 1: block idle and able to accept.
- `out_valid` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: final result. Held until the next accept or reset.

## Operation
- Accept occurs on an edge where state=IDLE, `start`=1 and `kill`=0. On accept the block latches `op`, both signs, and the operand magnitudes.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV and REM.
  - rs2 is signed for MULH, DIV and REM.
  - All other operands are unsigned; MUL uses the low product word, which is identical either way.
- States:
  - IDLE: `ready`=1. On accept, go to CALC; if the op is a special case, go to DONE instead.
  - CALC: 32 iterations, driven by a 5-bit counter that starts at 0. Go to FIX after count 31.
  - FIX: sign correction and result select. Go to DONE.
  - DONE: `out_valid`=1 for exactly one cycle, `ready`=0. Go to IDLE unconditionally.
- Multiply:
  - Each iteration: if multiplier bit 0 is set, add the multiplicand to the high accumulator. Then shift {carry, acc_hi, multiplier} right by 1.
  - FIX negates the 64-bit product when the operand signs differ (signed ops only).
  - MUL selects bits [31:0]; MULH, MULHSU and MULHU select bits [63:32].
- Divide:
  - Each iteration: shift {rem, quotient} left by 1 and trial-subtract the divisor from the 33-bit remainder.
  - If the result is non-negative, keep it and set quotient bit 0.
  - FIX negates the quotient when the signs differ, and gives the remainder the dividend's sign (signed ops only).
- Special cases skip CALC and FIX and go IDLE→DONE:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `in1`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `kill`:
  - In any state, forces IDLE on the next edge.
  - `out_valid` is suppressed, including when `kill` is asserted in DONE.
  - `result` is not updated.
  - When `kill` and `start` are both high in IDLE, `start` is ignored.
- `start` while not in IDLE is ignored; there is no queueing.
- `in1`, `in2` and `op` need only be stable during the accept cycle.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, counter=0.
  - `ready`=1 and `out_valid`=0 from the following cycle.
  - `result`=0.
  - Reset mid-operation discards the operation, with no `out_valid`.
  - Reset overrides `kill` and `start`.
- `ready` is decoded combinationally from state (state==IDLE). `out_valid` and `result` are registered.
- Normal op accepted at edge k:
  - CALC spans cycles k+1 … k+32.
  - FIX occurs in cycle k+33.
  - `out_valid` is high in cycle k+34 only.
  - `ready` is back to 1 in cycle k+35.
  - Latency is 34 cycles; throughput is one op per 35 cycles.
- Special-case op accepted at edge k: `out_valid` is high in cycle k+1; `ready` is 1 in cycle k+2.
- `kill` sampled at edge j: `ready` is 1 in cycle j+1, and a new accept can occur at edge j+1.
- The counter must not wrap into a 33rd iteration. The CALC→FIX transition is taken on count 31.

## Test plan
- Basic multiply: MUL `in1`=7, `in2`=0xFFFFFFFD.
  - Required: `result`=0xFFFFFFEB, with `out_valid` exactly 34 cycles after accept and a single-cycle pulse.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Signed high-word multiply:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0xFFFFFFFF×0x00000001 → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - REM 7/−2 → 1.
- Special cases, each with `out_valid` 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Kill: start DIVU, assert `kill` in CALC cycle 10.
  - Required: no `out_valid`, `ready`=1 the next cycle, and `result` unchanged.
  - An immediate MUL 3×4 then returns 12 at +34.
  - `kill` and `start` together in IDLE → no accept.
- Reset and protocol:
  - Drive `rst_n`=0 during CALC of a MUL → `ready`=1, `out_valid`=0 and `result`=0 after the reset edge.
  - `start` held high throughout a CALC → exactly one op is executed.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer on one shared 33-bit adder
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        kill,
  output logic        ready,
  output logic        out_valid,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t st, nxt;
  logic [2:0] op_q;
  logic neg1, neg2, v, sg1, sg2, n1, n2, div0, ovf, spec, accept, isdiv, ok;
  logic [31:0] a, hi, lo, m1, m2, spec_res, hi_n, lo_n, q, r, fix_res;
  logic [32:0] x, y, sum;
  logic [63:0] pn;
  logic [4:0] cnt;
  always_comb begin
    sg1 = (op == 3'b001) | (op == 3'b010) | (op[2] & ~op[0]);
    sg2 = (op == 3'b001) | (op[2] & ~op[0]);
    n1 = sg1 & in1[31];
    n2 = sg2 & in2[31];
    m1 = n1 ? -in1 : in1;
    m2 = n2 ? -in2 : in2;
    div0 = op[2] & (in2 == 32'd0);
    ovf = op[2] & ~op[0] & (in1 == 32'h8000_0000) & (in2 == 32'hffff_ffff);
    spec = div0 | ovf;
    spec_res = div0 ? (op[1] ? in1 : 32'hffff_ffff) : (op[1] ? 32'd0 : 32'h8000_0000);
    accept = (st == IDLE) & start & ~kill;
  end
  // Divide feeds {rem, quotient msb} and subtracts; multiply adds the gated multiplicand.
  always_comb begin
    isdiv = op_q[2];
    x = isdiv ? {hi, lo[31]} : {1'b0, hi};
    y = isdiv ? ~{1'b0, a} : (lo[0] ? {1'b0, a} : 33'd0);
    sum = x + y + {32'd0, isdiv};
    ok = ~sum[32];
    hi_n = isdiv ? (ok ? sum[31:0] : x[31:0]) : sum[32:1];
    lo_n = isdiv ? {lo[30:0], ok} : {sum[0], lo[31:1]};
    pn = (neg1 ^ neg2) ? -{hi, lo} : {hi, lo};
    q = (neg1 ^ neg2) ? -lo : lo;
    r = neg1 ? -hi : hi;
    fix_res = isdiv ? (op_q[1] ? r : q) : (op_q[1:0] == 2'b00 ? pn[31:0] : pn[63:32]);
  end
  always_comb begin
    nxt = kill ? IDLE :
          st == IDLE ? (start ? (spec ? DONE : CALC) : IDLE) :
          st == CALC ? (cnt == 5'd31 ? FIX : CALC) :
          st == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= 5'd0;
      v <= 1'b0;
      result <= 32'd0;
    end else begin
      st <= nxt;
      v <= ~kill & ((accept & spec) | (st == FIX));
      if (accept) begin
        op_q <= op;
        neg1 <= n1;
        neg2 <= n2;
        a <= op[2] ? m2 : m1;
        hi <= 32'd0;
        lo <= op[2] ? m1 : m2;
        cnt <= 5'd0;
        if (spec) result <= spec_res;
      end else if (st == CALC) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt + 5'd1;
      end
      if (st == FIX && !kill) result <= fix_res;
    end
  end
  assign ready = (st == IDLE);
  assign out_valid = v & ~kill;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
  logic clk = 0, rst_n = 0, start = 0, kill = 0;
  logic [2:0] op = 0;
  logic [31:0] in1 = 0, in2 = 0;
  logic ready, out_valid;
  logic [31:0] result;
  int checks = 0, fails = 0, pulses = 0, p0;
  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
                  .kill(kill), .ready(ready), .out_valid(out_valid), .result(result));
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input bit hold);
    int n;
    op = o; in1 = a; in2 = b; start = 1;
    @(posedge clk); #1;
    if (!hold) start = 0;
    op = 3'($urandom); in1 = $urandom; in2 = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    start = 0;
    check({tag, "_lat"}, n, lat);
    check(tag, result, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, out_valid}, 0);
    check({tag, "_rdy"}, {31'd0, ready}, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, ready}, 1);
    check("rst_ov", {31'd0, out_valid}, 0);
    check("rst_res", result, 0);
    rst_n = 1;
    run("mul", 3'b000, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 34, 0);
    run("mulhu", 3'b011, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 34, 0);
    run("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run("mulhsu", 3'b010, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 34, 0);
    run("mulh_neg1", 3'b001, 32'hffff_ffff, 32'h1, 32'hffff_ffff, 34, 0);
    run("div", 3'b100, -32'd7, 32'd2, 32'hffff_fffd, 34, 0);
    run("rem", 3'b110, -32'd7, 32'd2, 32'hffff_ffff, 34, 0);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    run("rem_negdiv", 3'b110, 32'd7, -32'd2, 32'd1, 34, 0);
    run("div0", 3'b100, 32'd5, 32'd0, 32'hffff_ffff, 1, 0);
    run("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1, 0);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hffff_ffff, 32'd0, 1, 0);
    p0 = pulses;
    op = 3'b101; in1 = 32'd100; in2 = 32'd7; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1;
    @(posedge clk); #1;
    kill = 0;
    check("kill_rdy", {31'd0, ready}, 1);
    check("kill_ov", {31'd0, out_valid}, 0);
    check("kill_res", result, 0);
    run("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 34, 0);
    check("kill_pulses", pulses, p0 + 1);
    op = 3'b000; in1 = 32'd9; in2 = 32'd9; start = 1; kill = 1;
    @(posedge clk); #1;
    start = 0; kill = 0;
    check("killstart_rdy", {31'd0, ready}, 1);
    p0 = pulses;
    repeat (40) @(posedge clk);
    #1;
    check("killstart_pulses", pulses, p0);
    check("killstart_res", result, 32'd12);
    p0 = pulses;
    run("hold", 3'b011, 32'd6, 32'd7, 32'd0, 34, 1);
    repeat (40) @(posedge clk);
    #1;
    check("hold_pulses", pulses, p0 + 1);
    check("hold_rdy", {31'd0, ready}, 1);
    p0 = pulses;
    op = 3'b000; in1 = 32'd5; in2 = 32'd6; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0; start = 1; kill = 1;
    @(posedge clk); #1;
    rst_n = 1; start = 0; kill = 0;
    check("midrst_rdy", {31'd0, ready}, 1);
    check("midrst_ov", {31'd0, out_valid}, 0);
    check("midrst_res", result, 0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_pulses", pulses, p0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
